mem_access_arbiter: RTL

- Two-port controller that shares the 8x8-bit memory macro between requesters A and B.
- Uses round-robin arbitration with a valid/ready request handshake.
- Sequences the memory's select/op/address/data pins, one access at a time.
- Returns a one-cycle response pulse: a write acknowledge, or read data captured after the macro's read latency.

---
 rtl/mem_access_arbiter_if.sv | 56 +++++
 rtl/mem_access_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter_if
// Purpose  : Bundles the two requester handshakes and the memory macro pins
//            shared between mem_access_arbiter and its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_arbiter_if;
  // Requester A
  logic       i_a_valid;
  logic       o_a_ready;
  logic       i_a_we;
  logic [2:0] i_a_adr;
  logic [7:0] i_a_wdata;
  logic       o_a_rsp_valid;
  logic [7:0] o_a_rdata;
  // Requester B
  logic       i_b_valid;
  logic       o_b_ready;
  logic       i_b_we;
  logic [2:0] i_b_adr;
  logic [7:0] i_b_wdata;
  logic       o_b_rsp_valid;
  logic [7:0] o_b_rdata;
  // Memory macro pins
  logic       o_mem_select;
  logic       o_mem_op;
  logic [2:0] o_mem_adr;
  logic [7:0] o_mem_din;
  logic [7:0] i_mem_dout;
  // Status
  logic       o_busy;

  // Arbiter side
  modport slave (
    input  i_a_valid, i_a_we, i_a_adr, i_a_wdata,
    output o_a_ready, o_a_rsp_valid, o_a_rdata,
    input  i_b_valid, i_b_we, i_b_adr, i_b_wdata,
    output o_b_ready, o_b_rsp_valid, o_b_rdata,
    output o_mem_select, o_mem_op, o_mem_adr, o_mem_din,
    input  i_mem_dout,
    output o_busy
  );

  // Requester / memory side
  modport master (
    output i_a_valid, i_a_we, i_a_adr, i_a_wdata,
    input  o_a_ready, o_a_rsp_valid, o_a_rdata,
    output i_b_valid, i_b_we, i_b_adr, i_b_wdata,
    input  o_b_ready, o_b_rsp_valid, o_b_rdata,
    input  o_mem_select, o_mem_op, o_mem_adr, o_mem_din,
    output i_mem_dout,
    input  o_busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter
// Purpose  : Round-robin arbiter sharing an 8x8 memory macro between two
//            valid/ready requesters, one access at a time, with a one-cycle
//            response pulse (write ack or read data).
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_arbiter #(
  parameter int RD_LATENCY = 1  // 1..4 cycles from read strobe to valid dout
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  mem_access_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] C_LAT_INIT = 3'(RD_LATENCY);

  state_t     state_q, state_d;
  logic       rr_q, rr_d;        // 0 = A has priority on a tie, 1 = B
  logic       owner_q, owner_d;  // 0 = A, 1 = B
  logic       we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] a_rdata_q, a_rdata_d;
  logic [7:0] b_rdata_q, b_rdata_d;
  logic       w_grant_a, w_grant_b;

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 3'd0;
      wdata_q   <= 8'd0;
      cnt_q     <= 3'd0;
      a_rdata_q <= 8'd0;
      b_rdata_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Arbitration, next-state and datapath update
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A wins when alone or when the pointer favours it on a tie
        if (bus.i_a_valid && (!bus.i_b_valid || !rr_q)) begin
          w_grant_a = 1'b1;
        end else if (bus.i_b_valid) begin
          w_grant_b = 1'b1;
        end
        if (w_grant_a || w_grant_b) begin
          owner_d = w_grant_b;
          we_d    = w_grant_b ? bus.i_b_we    : bus.i_a_we;
          adr_d   = w_grant_b ? bus.i_b_adr   : bus.i_a_adr;
          wdata_d = w_grant_b ? bus.i_b_wdata : bus.i_a_wdata;
          rr_d    = w_grant_a;  // next tie goes to the other requester
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = C_LAT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          if (owner_q) b_rdata_d = bus.i_mem_dout;
          else         a_rdata_d = bus.i_mem_dout;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake, response and memory pin outputs
  assign bus.o_a_ready     = w_grant_a;
  assign bus.o_b_ready     = w_grant_b;
  assign bus.o_a_rsp_valid = (state_q == S_RESP) && !owner_q;
  assign bus.o_b_rsp_valid = (state_q == S_RESP) &&  owner_q;
  assign bus.o_a_rdata     = a_rdata_q;
  assign bus.o_b_rdata     = b_rdata_q;
  assign bus.o_mem_select  = (state_q == S_ISSUE);
  assign bus.o_mem_op      = (state_q == S_ISSUE) && we_q;
  // Address and data come straight from the latched request so they hold
  // their last value when the macro is deselected
  assign bus.o_mem_adr     = adr_q;
  assign bus.o_mem_din     = wdata_q;
  assign bus.o_busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire
